// File: rtl/iob_cache_axi_arbiter.sv
// Round-robin AXI4 arbiter, N cache masters onto one port; one outstanding read and write, grant 1 cycle after request.
// Data paths zero latency, backpressure passed straight through; IOB_CACHE_ARB_FIXED_PRIO_EN selects fixed priority.
module iob_cache_axi_arbiter #(
   parameter int N_MASTERS  = 2,
   parameter int AXI_ID_W   = 1,
   parameter int AXI_ADDR_W = 24,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_LEN_W  = 8,
   parameter int GW   = $clog2(N_MASTERS),
   parameter int AW_W = AXI_ID_W + AXI_ADDR_W + AXI_LEN_W + 17,
   parameter int R_W  = AXI_ID_W + AXI_DATA_W + 3,
   parameter int W_W  = AXI_DATA_W + AXI_DATA_W / 8 + 1,
   parameter int B_W  = AXI_ID_W + 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N_MASTERS*AW_W-1:0] s_ar_i,
   input  logic [N_MASTERS-1:0]      s_arvalid_i,
   output logic [N_MASTERS-1:0]      s_arready_o,
   output logic [R_W-1:0]            s_r_o,
   output logic [N_MASTERS-1:0]      s_rvalid_o,
   input  logic [N_MASTERS-1:0]      s_rready_i,
   input  logic [N_MASTERS*AW_W-1:0] s_aw_i,
   input  logic [N_MASTERS-1:0]      s_awvalid_i,
   output logic [N_MASTERS-1:0]      s_awready_o,
   input  logic [N_MASTERS*W_W-1:0]  s_w_i,
   input  logic [N_MASTERS-1:0]      s_wvalid_i,
   output logic [N_MASTERS-1:0]      s_wready_o,
   output logic [B_W-1:0]            s_b_o,
   output logic [N_MASTERS-1:0]      s_bvalid_o,
   input  logic [N_MASTERS-1:0]      s_bready_i,
   output logic [AW_W-1:0]           m_ar_o,
   output logic                      m_arvalid_o,
   input  logic                      m_arready_i,
   input  logic [R_W-1:0]            m_r_i,
   input  logic                      m_rvalid_i,
   output logic                      m_rready_o,
   output logic [AW_W-1:0]           m_aw_o,
   output logic                      m_awvalid_o,
   input  logic                      m_awready_i,
   output logic [W_W-1:0]            m_w_o,
   output logic                      m_wvalid_o,
   input  logic                      m_wready_i,
   input  logic [B_W-1:0]            m_b_i,
   input  logic                      m_bvalid_i,
   output logic                      m_bready_o
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

   r_state_t       r_state;
   w_state_t       w_state;
   logic [GW-1:0]  rg;
   logic [GW-1:0]  wg;
   logic [GW-1:0]  r_pick;
   logic [GW-1:0]  w_pick;

   logic [AW_W-1:0] ar_arr [N_MASTERS];
   logic [AW_W-1:0] aw_arr [N_MASTERS];
   logic [W_W-1:0]  w_arr  [N_MASTERS];

   for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
      assign ar_arr[k] = s_ar_i[k*AW_W +: AW_W];
      assign aw_arr[k] = s_aw_i[k*AW_W +: AW_W];
      assign w_arr[k]  = s_w_i[k*W_W +: W_W];
   end

`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
   function automatic logic [GW-1:0] pick(input logic [N_MASTERS-1:0] req);
      logic [GW-1:0] g;
      g = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (req[i]) g = GW'(i);
      end
      return g;
   endfunction

   assign r_pick = pick(s_arvalid_i);
   assign w_pick = pick(s_awvalid_i);
`else
   logic [GW-1:0] r_last;
   logic [GW-1:0] w_last;

   // Search starts one past the last winner so every requester gets a turn.
   function automatic logic [GW-1:0] pick(input logic [N_MASTERS-1:0] req,
                                          input logic [GW-1:0]        last);
      logic [GW-1:0] g;
      logic          found;
      int            idx;
      g     = '0;
      found = 1'b0;
      for (int i = 1; i <= N_MASTERS; i++) begin
         idx = (int'(last) + i) % N_MASTERS;
         if (!found && req[idx]) begin
            g     = GW'(idx);
            found = 1'b1;
         end
      end
      return g;
   endfunction

   assign r_pick = pick(s_arvalid_i, r_last);
   assign w_pick = pick(s_awvalid_i, w_last);
`endif

   logic ar_hs, r_done, aw_hs, w_done, b_hs;

   assign ar_hs  = m_arvalid_o & m_arready_i;
   assign r_done = m_rvalid_i & m_rready_o & m_r_i[0];
   assign aw_hs  = m_awvalid_o & m_awready_i;
   assign w_done = m_wvalid_o & m_wready_i & m_w_o[0];
   assign b_hs   = m_bvalid_i & m_bready_o;

   assign s_r_o = m_r_i;
   assign s_b_o = m_b_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= R_IDLE;
         rg      <= '0;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
         r_last  <= GW'(N_MASTERS - 1);
`endif
      end else begin
         case (r_state)
            R_IDLE: begin
               if (|s_arvalid_i) begin
                  rg      <= r_pick;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
                  r_last  <= r_pick;
`endif
                  r_state <= R_ADDR;
               end
            end
            R_ADDR:  if (ar_hs)  r_state <= R_DATA;
            R_DATA:  if (r_done) r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state <= W_IDLE;
         wg      <= '0;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
         w_last  <= GW'(N_MASTERS - 1);
`endif
      end else begin
         case (w_state)
            W_IDLE: begin
               if (|s_awvalid_i) begin
                  wg      <= w_pick;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
                  w_last  <= w_pick;
`endif
                  w_state <= W_ADDR;
               end
            end
            W_ADDR:  if (aw_hs)  w_state <= W_DATA;
            W_DATA:  if (w_done) w_state <= W_RESP;
            W_RESP:  if (b_hs)   w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      m_ar_o      = ar_arr[rg];
      m_arvalid_o = 1'b0;
      s_arready_o = '0;
      s_rvalid_o  = '0;
      m_rready_o  = 1'b0;
      case (r_state)
         R_ADDR: begin
            m_arvalid_o     = s_arvalid_i[rg];
            s_arready_o[rg] = m_arready_i;
         end
         R_DATA: begin
            s_rvalid_o[rg] = m_rvalid_i;
            m_rready_o     = s_rready_i[rg];
         end
         default: ;
      endcase
   end

   // W is only exposed in W_DATA, i.e. strictly after the AW handshake.
   always_comb begin
      m_aw_o      = aw_arr[wg];
      m_w_o       = w_arr[wg];
      m_awvalid_o = 1'b0;
      s_awready_o = '0;
      m_wvalid_o  = 1'b0;
      s_wready_o  = '0;
      s_bvalid_o  = '0;
      m_bready_o  = 1'b0;
      case (w_state)
         W_ADDR: begin
            m_awvalid_o     = s_awvalid_i[wg];
            s_awready_o[wg] = m_awready_i;
         end
         W_DATA: begin
            m_wvalid_o     = s_wvalid_i[wg];
            s_wready_o[wg] = m_wready_i;
         end
         W_RESP: begin
            s_bvalid_o[wg] = m_bvalid_i;
            m_bready_o     = s_bready_i[wg];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_iob_cache_axi_arbiter.sv
// Directed bench for iob_cache_axi_arbiter: a 2-requester and a 4-requester instance.
module tb_iob_cache_axi_arbiter;
   localparam int AW_W = 50;
   localparam int R_W  = 36;
   localparam int W_W  = 37;
   localparam int B_W  = 3;

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   logic [2*AW_W-1:0] s_ar, s_aw;
   logic [2*W_W-1:0]  s_w;
   logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready;
   logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [R_W-1:0] s_r, m_r;
   logic [B_W-1:0] s_b, m_b;
   logic [AW_W-1:0] m_ar, m_aw;
   logic [W_W-1:0]  m_w;
   logic m_arvalid, m_arready, m_rvalid, m_rready;
   logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

   iob_cache_axi_arbiter #(.N_MASTERS(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_ar_i(s_ar), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
      .s_r_o(s_r), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
      .s_aw_i(s_aw), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
      .s_w_i(s_w), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
      .s_b_o(s_b), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
      .m_ar_o(m_ar), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
      .m_r_i(m_r), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
      .m_aw_o(m_aw), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
      .m_w_o(m_w), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
      .m_b_i(m_b), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready)
   );

   logic [4*AW_W-1:0] q_s_ar, q_s_aw;
   logic [4*W_W-1:0]  q_s_w;
   logic [3:0] q_s_arvalid, q_s_arready, q_s_rvalid, q_s_rready;
   logic [3:0] q_s_awvalid, q_s_awready, q_s_wvalid, q_s_wready, q_s_bvalid, q_s_bready;
   logic [R_W-1:0] q_s_r, q_m_r;
   logic [B_W-1:0] q_s_b, q_m_b;
   logic [AW_W-1:0] q_m_ar, q_m_aw;
   logic [W_W-1:0]  q_m_w;
   logic q_m_arvalid, q_m_arready, q_m_rvalid, q_m_rready;
   logic q_m_awvalid, q_m_awready, q_m_wvalid, q_m_wready, q_m_bvalid, q_m_bready;

   iob_cache_axi_arbiter #(.N_MASTERS(4)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_ar_i(q_s_ar), .s_arvalid_i(q_s_arvalid), .s_arready_o(q_s_arready),
      .s_r_o(q_s_r), .s_rvalid_o(q_s_rvalid), .s_rready_i(q_s_rready),
      .s_aw_i(q_s_aw), .s_awvalid_i(q_s_awvalid), .s_awready_o(q_s_awready),
      .s_w_i(q_s_w), .s_wvalid_i(q_s_wvalid), .s_wready_o(q_s_wready),
      .s_b_o(q_s_b), .s_bvalid_o(q_s_bvalid), .s_bready_i(q_s_bready),
      .m_ar_o(q_m_ar), .m_arvalid_o(q_m_arvalid), .m_arready_i(q_m_arready),
      .m_r_i(q_m_r), .m_rvalid_i(q_m_rvalid), .m_rready_o(q_m_rready),
      .m_aw_o(q_m_aw), .m_awvalid_o(q_m_awvalid), .m_awready_i(q_m_awready),
      .m_w_o(q_m_w), .m_wvalid_o(q_m_wvalid), .m_wready_i(q_m_wready),
      .m_b_i(q_m_b), .m_bvalid_i(q_m_bvalid), .m_bready_o(q_m_bready)
   );

   logic [14:0] outs;
   assign outs = {s_arready, s_rvalid, s_awready, s_wready, s_bvalid,
                  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready};
   logic [24:0] q_outs;
   assign q_outs = {q_s_arready, q_s_rvalid, q_s_awready, q_s_wready, q_s_bvalid,
                    q_m_arvalid, q_m_rready, q_m_awvalid, q_m_wvalid, q_m_bready};

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW_W-1:0] mk_ax(input logic id, input logic [23:0] addr,
                                             input logic [7:0] len);
      return {id, addr, len, 3'd2, 2'd1, 1'b0, 4'd3, 3'd0, 4'd0};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [AW_W-1:0] ar_exp;
   logic [R_W-1:0]  r_exp;
   logic [W_W-1:0]  w_exp;
   int beat, hs, n;
   int grants [5];
   int exp_g  [5];

   initial begin
      rst_i = 1'b1;
      s_ar = '0; s_aw = '0; s_w = '0;
      s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_bready = '0;
      m_r = '0; m_b = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
      q_s_ar = '0; q_s_aw = '0; q_s_w = '0;
      q_s_arvalid = '0; q_s_rready = '0; q_s_awvalid = '0; q_s_wvalid = '0; q_s_bready = '0;
      q_m_r = '0; q_m_b = '0;
      q_m_arready = 1'b0; q_m_rvalid = 1'b0; q_m_awready = 1'b0; q_m_wready = 1'b0;
      q_m_bvalid = 1'b0;
      for (int i = 0; i < 5; i++) grants[i] = -1;
`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0, 0};
`else
      exp_g = '{0, 1, 2, 3, 0};
`endif

      // Reset
      tick(); tick();
      chk("reset_outs", 64'(outs), 64'(15'h0));
      chk("reset_outs4", 64'(q_outs), 64'(25'h0));
      rst_i = 1'b0;
      settle();
      chk("post_reset_outs", 64'(outs), 64'(15'h0));

      // Both request reads with len=3: requester 0 first after reset
      s_ar[0 +: AW_W]    = mk_ax(1'b0, 24'h100040, 8'd3);
      s_ar[AW_W +: AW_W] = mk_ax(1'b1, 24'h200080, 8'd3);
      s_arvalid = 2'b11; m_arready = 1'b1; s_rready = 2'b11;
      settle();
      chk("idle_no_arvalid", 64'(m_arvalid), 64'(1'b0));
      tick(); settle();
      chk("rd0_arvalid", 64'(m_arvalid), 64'(1'b1));
      chk("rd0_addr", 64'(m_ar[48:25]), 64'(24'h100040));
      chk("rd0_arready", 64'(s_arready), 64'(2'b01));
      chk("rd0_no_rvalid", 64'(s_rvalid), 64'(2'b00));
      tick();
      s_arvalid = 2'b10; m_rvalid = 1'b1;
      for (int b = 0; b < 4; b++) begin
         r_exp = {1'b0, 32'hA000 + 32'(b), 2'b00, (b == 3)};
         m_r = r_exp;
         settle();
         chk("rd0_rvalid", 64'(s_rvalid), 64'(2'b01));
         chk("rd0_rdata", 64'(s_r), 64'(r_exp));
         chk("rd0_rready", 64'(m_rready), 64'(1'b1));
         tick();
      end
      m_rvalid = 1'b0;
      settle();
      chk("rd0_back_idle", 64'(m_arvalid), 64'(1'b0));
      chk("rd0_idle_rvalid", 64'(s_rvalid), 64'(2'b00));
      tick(); settle();
      chk("rd1_arready", 64'(s_arready), 64'(2'b10));
      chk("rd1_addr", 64'(m_ar[48:25]), 64'(24'h200080));
      chk("rd1_arvalid", 64'(m_arvalid), 64'(1'b1));
      tick();
      s_arvalid = 2'b00; m_rvalid = 1'b1;

      // Requester 1 drains its burst with rready toggling every cycle
      beat = 0; hs = 0;
      for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
         s_rready = {cyc[0], 1'b1};
         m_r = {1'b1, 32'hB000 + 32'(beat), 2'b00, (beat == 3)};
         settle();
         chk("bp_rvalid", 64'(s_rvalid), 64'(2'b10));
         chk("bp_rready", 64'(m_rready), 64'(s_rready[1]));
         if (m_rready && m_rvalid) hs++;
         if (s_rready[1]) beat++;
         tick();
      end
      settle();
      chk("bp_beat_count", 64'(hs), 64'(4));
      chk("bp_no_extra_beat", 64'(s_rvalid), 64'(2'b00));
      chk("bp_idle_rready", 64'(m_rready), 64'(1'b0));
      m_rvalid = 1'b0; s_rready = 2'b11;

      // arready held low for 5 cycles
      ar_exp = mk_ax(1'b0, 24'h0ABCDE, 8'd0);
      s_ar[0 +: AW_W] = ar_exp;
      s_arvalid = 2'b01; m_arready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_arvalid", 64'(m_arvalid), 64'(1'b1));
         chk("stall_payload", 64'(m_ar), 64'(ar_exp));
         chk("stall_arready", 64'(s_arready), 64'(2'b00));
         tick();
      end
      m_arready = 1'b1;
      settle();
      chk("stall_release", 64'(s_arready), 64'(2'b01));
      tick();
      s_arvalid = 2'b00; m_rvalid = 1'b1;
      r_exp = {1'b0, 32'hC0FFEE00, 2'b10, 1'b1};
      m_r = r_exp;
      settle();
      chk("stall_rvalid", 64'(s_rvalid), 64'(2'b01));
      chk("stall_rdata", 64'(s_r), 64'(r_exp));
      tick();
      m_rvalid = 1'b0;
      settle();
      chk("stall_done", 64'(m_rready), 64'(1'b0));

      // Requester 1 writes 2 beats while requester 0 reads one beat
      ar_exp = mk_ax(1'b1, 24'h300000, 8'd1);
      s_aw[AW_W +: AW_W] = ar_exp;
      w_exp = {32'hD0000000, 4'hF, 1'b0};
      s_w[W_W +: W_W] = w_exp;
      s_awvalid = 2'b10; s_wvalid = 2'b10;
      m_awready = 1'b1; m_wready = 1'b1; s_bready = 2'b11;
      s_ar[0 +: AW_W] = mk_ax(1'b0, 24'h000400, 8'd0);
      s_arvalid = 2'b01; m_arready = 1'b1;
      settle();
      chk("wr_idle_wvalid", 64'(m_wvalid), 64'(1'b0));
      chk("wr_idle_awvalid", 64'(m_awvalid), 64'(1'b0));
      tick(); settle();
      chk("wr_awvalid", 64'(m_awvalid), 64'(1'b1));
      chk("wr_aw_payload", 64'(m_aw), 64'(ar_exp));
      chk("wr_awready", 64'(s_awready), 64'(2'b10));
      chk("wr_w_before_aw", 64'(m_wvalid), 64'(1'b0));
      chk("wr_wready_before_aw", 64'(s_wready), 64'(2'b00));
      chk("cc_arvalid", 64'(m_arvalid), 64'(1'b1));
      chk("cc_arready", 64'(s_arready), 64'(2'b01));
      tick();
      s_arvalid = 2'b00; s_awvalid = 2'b00;
      m_rvalid = 1'b1; m_r = {1'b0, 32'h11111111, 2'b00, 1'b1};
      settle();
      chk("cc_rvalid", 64'(s_rvalid), 64'(2'b01));
      chk("wr_wvalid0", 64'(m_wvalid), 64'(1'b1));
      chk("wr_wdata0", 64'(m_w), 64'(w_exp));
      chk("wr_wready0", 64'(s_wready), 64'(2'b10));
      tick();
      m_rvalid = 1'b0;
      w_exp = {32'hD0000001, 4'hF, 1'b1};
      s_w[W_W +: W_W] = w_exp;
      settle();
      chk("cc_read_idle", 64'(s_rvalid), 64'(2'b00));
      chk("wr_wdata1", 64'(m_w), 64'(w_exp));
      chk("wr_wvalid1", 64'(m_wvalid), 64'(1'b1));
      tick();
      s_wvalid = 2'b00; m_bvalid = 1'b1; m_b = 3'b100;
      settle();
      chk("wr_resp_no_w", 64'(m_wvalid), 64'(1'b0));
      chk("wr_bvalid", 64'(s_bvalid), 64'(2'b10));
      chk("wr_bready", 64'(m_bready), 64'(1'b1));
      chk("wr_bdata", 64'(s_b), 64'(3'b100));
      tick(); settle();
      chk("wr_b_done", 64'(s_bvalid), 64'(2'b00));
      chk("wr_b_done_rdy", 64'(m_bready), 64'(1'b0));
      m_bvalid = 1'b0;

      // Reset in the middle of a 4-beat write burst
      s_aw[0 +: AW_W] = mk_ax(1'b0, 24'h400000, 8'd3);
      s_awvalid = 2'b01;
      tick(); settle();
      chk("wr0_awready", 64'(s_awready), 64'(2'b01));
      tick();
      s_awvalid = 2'b00; s_wvalid = 2'b01;
      s_w[0 +: W_W] = {32'hE0, 4'hF, 1'b0};
      settle();
      chk("wr0_wready", 64'(s_wready), 64'(2'b01));
      tick();
      s_w[0 +: W_W] = {32'hE1, 4'hF, 1'b0};
      tick();
      rst_i = 1'b1;
      settle();
      chk("rst_mid_burst", 64'(outs), 64'(15'h0));
      tick();
      rst_i = 1'b0; s_wvalid = 2'b00;
      settle();
      chk("rst_release", 64'(outs), 64'(15'h0));
      s_ar[0 +: AW_W] = mk_ax(1'b0, 24'h500000, 8'd0);
      s_arvalid = 2'b01; m_arready = 1'b1;
      tick(); settle();
      chk("post_rst_arready", 64'(s_arready), 64'(2'b01));
      chk("post_rst_addr", 64'(m_ar[48:25]), 64'(24'h500000));
      tick();
      s_arvalid = 2'b00; m_rvalid = 1'b1;
      m_r = {1'b0, 32'h5A5A5A5A, 2'b00, 1'b1};
      settle();
      chk("post_rst_rvalid", 64'(s_rvalid), 64'(2'b01));
      tick();
      m_rvalid = 1'b0;
      settle();
      chk("post_rst_idle", 64'({s_rvalid, m_arvalid}), 64'(3'b000));

      // Four requesters reading continuously
      for (int k = 0; k < 4; k++)
         q_s_ar[k*AW_W +: AW_W] = mk_ax(1'b0, 24'h600000 + 24'(k * 256), 8'd0);
      q_s_arvalid = 4'hF; q_m_arready = 1'b1; q_s_rready = 4'hF;
      q_m_rvalid = 1'b1; q_m_r = {1'b0, 32'h77, 2'b00, 1'b1};
      n = 0;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
         settle();
         if (q_s_arready != 4'h0) begin
            for (int k = 0; k < 4; k++)
               if (q_s_arready[k]) grants[n] = k;
            n++;
         end
         tick();
      end
      q_s_arvalid = 4'h0; q_m_rvalid = 1'b0;
      chk("rr4_grant_count", 64'(n), 64'(5));
      for (int i = 0; i < 5; i++)
         chk("rr4_grant_seq", 64'(grants[i]), 64'(exp_g[i]));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
